uart_boot_loader: RTL and testbench

Receive-side boot stage upstream of the CPU core. It consumes the byte stream from the UART receiver and assembles little-endian 32-bit words. It writes them into instruction memory from word address 0 and holds the core in reset until a complete, checksum-verified image has been stored. After a successful load it releases the core and ignores further UART traffic.

---
 rtl/uart_boot_loader_if.sv | 22 ++
 rtl/uart_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Byte stream from the UART receiver and the instruction-memory write port
// of the boot loader. The loader uses the slave modport; the environment
// that feeds bytes and watches writes uses the master modport.
interface uart_boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: frames A5, LEN lo, LEN hi, N*4 payload bytes (LSB first),
// XOR checksum. Writes words to instruction memory from address 0 and holds
// the core in reset until a verified image is stored.
// Optional inter-byte timeout: define BOOT_TIMEOUT_EN.
module uart_boot_loader #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  uart_boot_loader_if.slave bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(64'd1 << ADDR_W);
  localparam logic [7:0]  SYNC      = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        xsum_q, xsum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_d, done_d, error_d;
  logic [15:0]       n_c;
  logic              timeout_c;

  assign n_c            = {bus.rx_data, len_q[7:0]};
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  // A zero timeout would fire on the first idle cycle of every frame.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef BOOT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            active_c;

  assign active_c  = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
  assign timeout_c = active_c && !bus.rx_valid &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive idle cycles while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst || !active_c || bus.rx_valid) to_cnt_q <= '0;
    else                                  to_cnt_q <= to_cnt_q + TO_W'(1);
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State and datapath registers; outputs are registered copies of *_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      xsum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      xsum_q     <= xsum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst    <= cpu_rst_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // Frame parser: every transition is gated by rx_valid except the timeout.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    xsum_d     = xsum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst;
    done_d     = done;
    error_d    = error;

    if (timeout_c) begin
      state_d = S_ERR;
      error_d = 1'b1;
    end else if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == SYNC) begin
            state_d    = S_LEN0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
          end
        end
        S_LEN0: begin
          len_d[7:0] = bus.rx_data;
          xsum_d     = '0;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d[15:8] = bus.rx_data;
          if (17'(n_c) > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (n_c == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          xsum_d     = xsum_q ^ bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = bus.rx_data;
            2'd1: asm_d[15:8]  = bus.rx_data;
            2'd2: asm_d[23:16] = bus.rx_data;
            default: begin
              we_d       = 1'b1;
              addr_d     = word_cnt_q[ADDR_W-1:0];
              wdata_d    = {bus.rx_data, asm_q};
              word_cnt_d = word_cnt_q + CNT_W'(1);
              if (17'(word_cnt_q) + 17'd1 == 17'(len_q)) state_d = S_CSUM;
            end
          endcase
        end
        S_CSUM: begin
          if (bus.rx_data == xsum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        S_ERR: begin
          if (bus.rx_data == SYNC) begin
            state_d    = S_LEN0;
            error_d    = 1'b0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: dut0 uses ADDR_W=10, dut1 uses
// ADDR_W=2 for the capacity boundary. Expected writes are queued by the
// stimulus and popped by per-DUT write monitors.
module tb_uart_boot_loader;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic cpu_rst0, done0, error0;
  logic cpu_rst1, done1, error1;

  int checks = 0;
  int errors = 0;

  wr_t        exp_q0[$];
  wr_t        exp_q1[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(10)) bus0 ();
  uart_boot_loader_if #(.ADDR_W(2))  bus1 ();

  uart_boot_loader #(.ADDR_W(10), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0),
    .cpu_rst(cpu_rst0), .done(done0), .error(error0)
  );

  uart_boot_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .cpu_rst(cpu_rst1), .done(done1), .error(error1)
  );

  // Write monitor for dut0.
  always @(negedge clk) begin
    if (bus0.imem_we === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_write: unexpected write addr=%0d data=%h", bus0.imem_addr, bus0.imem_wdata);
      end else begin
        e = exp_q0.pop_front();
        if (32'(bus0.imem_addr) !== e.addr || bus0.imem_wdata !== e.data) begin
          errors++;
          $display("FAIL dut0_write: got addr=%0d data=%h expected addr=%0d data=%h",
                   bus0.imem_addr, bus0.imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Write monitor for dut1.
  always @(negedge clk) begin
    if (bus1.imem_we === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_write: unexpected write addr=%0d data=%h", bus1.imem_addr, bus1.imem_wdata);
      end else begin
        e = exp_q1.pop_front();
        if (32'(bus1.imem_addr) !== e.addr || bus1.imem_wdata !== e.data) begin
          errors++;
          $display("FAIL dut1_write: got addr=%0d data=%h expected addr=%0d data=%h",
                   bus1.imem_addr, bus1.imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic exp_w(input int sel, input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    if (sel == 0) exp_q0.push_back(w);
    else          exp_q1.push_back(w);
  endtask

  // Drive tx_q back-to-back, one byte per cycle; returns at the negedge
  // following the edge that sampled the last byte.
  task automatic send(input int sel);
    logic [7:0] b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      if (sel == 0) begin bus0.rx_valid = 1'b1; bus0.rx_data = b; end
      else          begin bus1.rx_valid = 1'b1; bus1.rx_data = b; end
      @(negedge clk);
    end
    bus0.rx_valid = 1'b0;
    bus1.rx_valid = 1'b0;
  endtask

  task automatic pulse_rst(input int sel);
    if (sel == 0) rst0 = 1'b1; else rst1 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
  endtask

  task automatic chk_st(input int sel, input string name,
                        input logic e_done, input logic e_err, input logic e_rst);
    logic [2:0] got;
    logic [2:0] exp;
    got = (sel == 0) ? {done0, error0, cpu_rst0} : {done1, error1, cpu_rst1};
    exp = {e_done, e_err, e_rst};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: done/error/cpu_rst=%b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_drained(input int sel, input string name);
    int n;
    n = (sel == 0) ? exp_q0.size() : exp_q1.size();
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s: %0d expected writes missing, required 0", name, n);
    end
  endtask

  task automatic chk_reset_outputs(input int sel, input string name);
    logic [32:0] got;
    got = (sel == 0) ? {bus0.imem_we, 32'(bus0.imem_addr) | bus0.imem_wdata}
                     : {bus1.imem_we, 32'(bus1.imem_addr) | bus1.imem_wdata};
    checks++;
    if (got !== 33'd0) begin
      errors++;
      $display("FAIL %s: imem we/addr|wdata=%h expected 0", name, got);
    end
    chk_st(sel, name, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.rx_valid = 1'b0; bus0.rx_data = 8'h00;
    bus1.rx_valid = 1'b0; bus1.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    chk_reset_outputs(0, "reset_dut0");
    chk_reset_outputs(1, "reset_dut1");

    // Noise, then nominal two-word load.
    tx_q = '{8'h00, 8'hFF, 8'h5A};
    send(0);
    chk_st(0, "noise_ignored", 1'b0, 1'b0, 1'b1);
    exp_w(0, 0, 32'h0000_0013);
    exp_w(0, 1, 32'h0010_0093);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send(0);
    chk_st(0, "nominal_done", 1'b1, 1'b0, 1'b0);
    chk_drained(0, "nominal_writes");

    // Traffic after done is ignored.
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(0);
    repeat (2) @(negedge clk);
    chk_st(0, "post_done_sticky", 1'b1, 1'b0, 1'b0);

    // Bad checksum, then recovery by resending.
    pulse_rst(0);
    chk_reset_outputs(0, "reset_after_done");
    exp_w(0, 0, 32'h0000_0013);
    exp_w(0, 1, 32'h0010_0093);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    send(0);
    chk_st(0, "bad_csum_error", 1'b0, 1'b1, 1'b1);
    chk_drained(0, "bad_csum_writes");
    tx_q = '{8'h13, 8'h77};
    send(0);
    chk_st(0, "err_ignores_bytes", 1'b0, 1'b1, 1'b1);
    exp_w(0, 0, 32'h0000_0013);
    exp_w(0, 1, 32'h0010_0093);
    tx_q = '{8'hA5};
    send(0);
    chk_st(0, "sync_clears_error", 1'b0, 1'b0, 1'b1);
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send(0);
    chk_st(0, "recovered_done", 1'b1, 1'b0, 1'b0);
    chk_drained(0, "recovered_writes");

    // Zero-length image.
    pulse_rst(0);
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send(0);
    chk_st(0, "zero_len_done", 1'b1, 1'b0, 1'b0);

    // Reset after the second payload byte discards the partial word.
    pulse_rst(0);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
    send(0);
    pulse_rst(0);
    chk_st(0, "midword_rst", 1'b0, 1'b0, 1'b1);
    exp_w(0, 0, 32'h1234_5678);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send(0);
    chk_st(0, "after_midword_done", 1'b1, 1'b0, 1'b0);
    chk_drained(0, "after_midword_writes");

    // Oversize length on the 4-word instance, then a full-capacity load.
    tx_q = '{8'hA5, 8'h05, 8'h00};
    send(1);
    chk_st(1, "oversize_error", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      exp_w(1, 32'(i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    tx_q = '{8'hA5, 8'h04, 8'h00};
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h00);
    send(1);
    chk_st(1, "full_capacity_done", 1'b1, 1'b0, 1'b0);
    chk_drained(1, "full_capacity_writes");

`ifdef BOOT_TIMEOUT_EN
    // 16 idle cycles mid-word reach the timeout.
    pulse_rst(0);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13};
    send(0);
    repeat (15) @(negedge clk);
    chk_st(0, "before_timeout", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_st(0, "timeout_error", 1'b0, 1'b1, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk_drained(0, "final_dut0");
    chk_drained(1, "final_dut1");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
